// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, IF/ID bundle and fetch state encoding
package cpu_pkg;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [5:0] OPC_J = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;
  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};
  typedef enum logic {FETCH, HALT} fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register; squash beats load, neither means hold
import cpu_pkg::*;
module ifid_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        squash,
  input  logic [31:0] d_instr,
  input  logic [31:0] d_pc_plus4,
  output logic [31:0] q_instr,
  output logic [31:0] q_pc_plus4,
  output logic        q_valid
);
  ifid_t r_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= IFID_BUBBLE;
    else if (squash) r_q <= IFID_BUBBLE;
    else if (load) r_q <= '{instr: d_instr, pc_plus4: d_pc_plus4, valid: 1'b1};
  end
  assign q_instr = r_q.instr;
  assign q_pc_plus4 = r_q.pc_plus4;
  assign q_valid = r_q.valid;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and insmem initiator feeding the IF/ID register
import cpu_pkg::*;
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);
  fetch_state_t r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next, w_pc4, w_jump_target, r_count;
  logic w_oor, w_squash, w_load;
  assign w_pc4 = r_pc + PC_STEP;
  assign w_jump_target = {ifid_pc_plus4[31:28], jump_index, 2'b00};
  assign w_oor = ({2'b00, r_pc[31:2]} >= 32'(IMEM_DEPTH)) || (r_pc[1:0] != 2'b00);
  always_comb begin
    w_state_next = r_state;
    w_pc_next = r_pc;
    w_squash = 1'b0;
    w_load = 1'b0;
    if (branch_taken) begin
      w_pc_next = branch_target;
      w_squash = 1'b1;
      w_state_next = FETCH;
    end else if (jump) begin
      w_pc_next = w_jump_target;
      w_squash = 1'b1;
      w_state_next = FETCH;
    end else if (!stall) begin
      // imem_instr is only consumed on the in-range path
      if (w_oor) begin
        w_squash = 1'b1;
        w_state_next = HALT;
      end else begin
        w_pc_next = w_pc4;
        w_load = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= FETCH;
      r_pc <= RESET_PC;
      r_count <= 32'h0;
    end else begin
      r_state <= w_state_next;
      r_pc <= w_pc_next;
      if (w_load && !(&r_count)) r_count <= r_count + 32'd1;
    end
  end
  ifid_reg u_ifid (
    .clk(clk),
    .reset(reset),
    .load(w_load),
    .squash(w_squash),
    .d_instr(imem_instr),
    .d_pc_plus4(w_pc4),
    .q_instr(ifid_instr),
    .q_pc_plus4(ifid_pc_plus4),
    .q_valid(ifid_valid)
  );
  assign imem_addr = r_pc;
  assign halted = (r_state == HALT);
  assign fetch_count = r_count;
endmodule
